// File: rtl/sfm_pipe_arbiter.sv
// rtl/sfm_pipe_arbiter.sv - round-robin share of one elastic pipeline with in-order tag return routing
// Beats are issued round-robin; a tag FIFO remembers each issuer so returns route back in order.
module sfm_pipe_arbiter #(
  parameter  int NUM_REQ         = 2,
  parameter  int WIDTH_IN        = 32,
  parameter  int WIDTH_OUT       = WIDTH_IN,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int ID_W            = $clog2(NUM_REQ),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 enable_i,
  input  logic                                 clear_i,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [NUM_REQ-1:0][WIDTH_IN-1:0]     req_data_i,
  output logic                                 pipe_valid_o,
  input  logic                                 pipe_ready_i,
  output logic [WIDTH_IN-1:0]                  pipe_data_o,
  input  logic                                 pipe_valid_i,
  output logic                                 pipe_ready_o,
  input  logic [WIDTH_OUT-1:0]                 pipe_data_i,
  output logic [NUM_REQ-1:0]                   rsp_valid_o,
  input  logic [NUM_REQ-1:0]                   rsp_ready_i,
  output logic [NUM_REQ-1:0][WIDTH_OUT-1:0]    rsp_data_o,
  output logic [CNT_W-1:0]                     outstanding_o,
  output logic                                 busy_o,
  output logic                                 error_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             error_q, error_d;
  logic [ID_W-1:0]  tag_q [MAX_OUTSTANDING];

  logic             can_issue, nonempty, push, pop, found;
  logic [ID_W-1:0]  grant, head, scan_id;

  function automatic logic [PTR_W-1:0] fifo_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Full blocks issue even when a pop lands the same cycle: keeps readies free of a ready-to-ready path.
  assign nonempty  = (count_q != '0);
  assign can_issue = enable_i && (count_q < CNT_W'(MAX_OUTSTANDING));
  assign head      = tag_q[rd_ptr_q];

  always_comb begin
    grant   = ptr_q;
    found   = 1'b0;
    scan_id = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_id = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && req_valid_i[scan_id]) begin
        grant = scan_id;
        found = 1'b1;
      end
    end
  end

  assign pipe_valid_o = can_issue && (|req_valid_i);
  assign pipe_data_o  = req_data_i[grant];
  assign push         = pipe_valid_o && pipe_ready_i;

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready_o[k] = can_issue && pipe_ready_i && (grant == ID_W'(k)) && req_valid_i[k];
      rsp_valid_o[k] = enable_i && pipe_valid_i && nonempty && (head == ID_W'(k));
    end
  end

  assign pipe_ready_o  = enable_i && nonempty && rsp_ready_i[head];
  assign pop           = pipe_valid_i && pipe_ready_o;
  assign rsp_data_o    = {NUM_REQ{pipe_data_i}};
  assign outstanding_o = count_q;
  assign busy_o        = nonempty;
  assign error_o       = error_q;

  always_comb begin
    ptr_d    = ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q;
    if (push) begin
      ptr_d    = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
      wr_ptr_d = fifo_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = fifo_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    if (enable_i && pipe_valid_i && !nonempty) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      ptr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
      if (push) begin
        tag_q[wr_ptr_q] <= grant;
      end
    end
  end

endmodule

// File: tb/tb_sfm_pipe_arbiter.sv
// tb/tb_sfm_pipe_arbiter.sv - self-checking bench for sfm_pipe_arbiter against a queue-based model
module tb_sfm_pipe_arbiter;
  localparam int NR = 2;
  localparam int W  = 32;
  localparam int MO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, en, clr, pr, pv;
  logic [NR-1:0]        rv, rr, rdy_o, rspv_o;
  logic [NR-1:0][W-1:0] rdata, rspd_o;
  logic [W-1:0]         pdata_o, pdata_i;
  logic                 pvalid_o, pready_o, busy_o, err_o;
  logic [2:0]           outst_o;

  sfm_pipe_arbiter #(.NUM_REQ(NR), .WIDTH_IN(W), .WIDTH_OUT(W), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr),
    .req_valid_i(rv), .req_ready_o(rdy_o), .req_data_i(rdata),
    .pipe_valid_o(pvalid_o), .pipe_ready_i(pr), .pipe_data_o(pdata_o),
    .pipe_valid_i(pv), .pipe_ready_o(pready_o), .pipe_data_i(pdata_i),
    .rsp_valid_o(rspv_o), .rsp_ready_i(rr), .rsp_data_o(rspd_o),
    .outstanding_o(outst_o), .busy_o(busy_o), .error_o(err_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: in-flight tags as a queue, arbitration by modular search.
  int mq[$];
  int mptr = 0;
  bit merr = 0;
  int e_grant;
  bit e_pvalid, e_pready, e_push, e_pop;
  logic [NR-1:0] e_rdy, e_rspv;

  bit log_grant = 0;
  int obs[$];
  int seq[10] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1};

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic void model_eval();
    int  cnt;
    bit  can, hit;
    cnt     = mq.size();
    can     = en && (cnt < MO);
    e_grant = mptr;
    hit     = 0;
    for (int i = 0; i < NR; i++) begin
      if (!hit && rv[(mptr + i) % NR]) begin
        e_grant = (mptr + i) % NR;
        hit     = 1;
      end
    end
    e_pvalid = can && (rv != '0);
    e_rdy    = '0;
    if (can && pr && rv[e_grant]) e_rdy[e_grant] = 1'b1;
    e_push   = e_pvalid && pr;
    e_rspv   = '0;
    e_pready = 0;
    if (cnt > 0) begin
      if (en && pv) e_rspv[mq[0]] = 1'b1;
      e_pready = en && rr[mq[0]];
    end
    e_pop = pv && e_pready;
  endfunction

  function automatic void model_update();
    if (!rst_n || clr) begin
      mq.delete();
      mptr = 0;
      merr = 0;
    end else begin
      if (en && pv && mq.size() == 0) merr = 1;
      if (e_pop) void'(mq.pop_front());
      if (e_push) begin
        mq.push_back(e_grant);
        mptr = (e_grant + 1) % NR;
      end
    end
  endfunction

  task automatic cycle(input bit chk);
    for (int k = 0; k < NR; k++) rdata[k] = $urandom;
    pdata_i = $urandom;
    #1;
    model_eval();
    if (chk) begin
      check("pipe_valid", pvalid_o, e_pvalid);
      check("req_ready", rdy_o, e_rdy);
      check("pipe_ready", pready_o, e_pready);
      check("rsp_valid", rspv_o, e_rspv);
      check("outstanding", outst_o, mq.size());
      check("busy", busy_o, mq.size() != 0);
      check("error", err_o, merr);
      check("rsp_data", rspd_o, {pdata_i, pdata_i});
      if (e_pvalid) check("pipe_data", pdata_o, rdata[e_grant]);
    end
    if (log_grant && rdy_o != '0) obs.push_back(rdy_o[1] ? 1 : 0);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    cycle(1);
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; pr = 1'b1; pv = 1'b0;
    rv = '0; rr = '0; rdata = '0; pdata_i = '0;
    cycle(0);
    cycle(1);
    rst_n = 1'b1;
    check("reset_outstanding", outst_o, 0);
    check("reset_error", err_o, 0);

    // Round-robin fairness with immediate returns
    rv = 2'b11; rr = 2'b11; pr = 1'b1;
    log_grant = 1;
    for (int i = 0; i < 4; i++) begin
      pv = (mq.size() != 0);
      cycle(1);
    end
    log_grant = 0;
    check("rr_count", obs.size(), 4);
    for (int i = 0; i < obs.size(); i++) check("rr_order", obs[i], i % 2);

    // Credit limit
    pulse_clear();
    rv = 2'b01; pv = 1'b0;
    repeat (6) cycle(1);
    #1;
    check("credit_full", outst_o, 4);
    check("credit_busy", busy_o, 1);
    check("credit_noready", rdy_o, 0);
    pv = 1'b1; rr = 2'b11;
    cycle(1);
    pv = 1'b0;
    check("credit_after_pop", outst_o, 3);
    cycle(1);
    check("credit_refill", outst_o, 4);

    // Response backpressure with head = 1
    pulse_clear();
    rv = 2'b10;
    cycle(1);
    rv = 2'b00; pv = 1'b1; rr = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", pready_o, 0);
      check("bp_rspv", rspv_o, 2'b10);
      cycle(1);
    end
    check("bp_held", outst_o, 1);
    rr = 2'b10;
    #1;
    check("bp_release", pready_o, 1);
    cycle(1);
    check("bp_popped", outst_o, 0);

    // Simultaneous push/pop at count 2, tag order across pointer wrap
    pv = 1'b0;
    pulse_clear();
    rv = 2'b11;
    repeat (2) cycle(1);
    pv = 1'b1; rr = 2'b11;
    for (int i = 0; i < 10; i++) begin
      rv = 2'(1 << seq[i]);
      cycle(1);
      check("pushpop_count", outst_o, 2);
    end

    // Spurious return and clear
    pulse_clear();
    rv = 2'b00; pv = 1'b1;
    #1;
    check("spur_ready", pready_o, 0);
    cycle(1);
    pv = 1'b0;
    check("spur_error", err_o, 1);
    repeat (2) cycle(1);
    check("spur_sticky", err_o, 1);
    pulse_clear();
    check("clear_error", err_o, 0);
    check("clear_outstanding", outst_o, 0);

    // Reset mid-operation
    rv = 2'b01;
    repeat (3) cycle(1);
    check("pre_reset_count", outst_o, 3);
    rv = 2'b00; rst_n = 1'b0;
    cycle(1);
    rst_n = 1'b1;
    pv = 1'b1;
    #1;
    check("rst_outstanding", outst_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rspv", rspv_o, 0);
    pv = 1'b0; rv = 2'b11;
    #1;
    check("rst_first_grant", rdy_o, 2'b01);
    cycle(1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 59) == 0);
      rv  = NR'($urandom);
      rr  = NR'($urandom);
      pr  = ($urandom_range(0, 3) != 0);
      pv  = (mq.size() != 0) ? $urandom_range(0, 1) : ($urandom_range(0, 29) == 0);
      cycle(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
